// File: rtl/pc_pkg.sv
// Shared constants for the PC / instruction-fetch slice.
// The ROM image is a fixed, index-dependent pattern, so every word can be identified.
package pc_pkg;

   localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
   localparam int          PC_STEP       = 4;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

   function automatic logic [31:0] rom_word(input logic [31:0] idx);
      return 32'hDEAD_0000 ^ (idx * 32'h0001_0101);
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls in, PC and IF/ID contents out.
interface pc_fetch_unit_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 16
);
   logic               Stall;
   logic               Redir;
   logic [ADDR_W-1:0]  Redir_Addr;
   logic [ADDR_W-1:0]  Pc;
   logic [ADDR_W-1:0]  If_Pc;
   logic [INSTR_W-1:0] If_Instr;
   logic               If_Valid;
   logic [CNT_W-1:0]   Fetch_Cnt;

   modport master (
      output Stall, Redir, Redir_Addr,
      input  Pc, If_Pc, If_Instr, If_Valid, Fetch_Cnt
   );

   modport slave (
      input  Stall, Redir, Redir_Addr,
      output Pc, If_Pc, If_Instr, If_Valid, Fetch_Cnt
   );
endinterface

// File: rtl/pc_fetch_unit_im_rom.sv
// Instruction ROM with combinational read; word i is pc_pkg::rom_word(i).
module im_rom
   import pc_pkg::*;
#(
   parameter int IM_AW   = 6,
   parameter int INSTR_W = 32
) (
   input  logic [IM_AW-1:0]   i_addr,
   output logic [INSTR_W-1:0] o_word
);

   logic [INSTR_W-1:0] w_rom [2**IM_AW];

   for (genvar g = 0; g < 2**IM_AW; g++) begin : g_rom
      assign w_rom[g] = INSTR_W'(rom_word(32'(g)));
   end

   assign o_word = w_rom[i_addr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus IF/ID register; redirect beats stall beats sequential fetch.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int               ADDR_W    = 32,
   parameter int               INSTR_W   = 32,
   parameter int               IM_AW     = 6,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
   parameter int               CNT_W     = 16
) (
   input  logic            Clk,
   input  logic            Rst,
   pc_fetch_unit_if.slave  bus
);

   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_if_pc;
   logic [INSTR_W-1:0] r_if_instr;
   logic               r_if_valid;
   logic [CNT_W-1:0]   r_fetch_cnt;

   logic [ADDR_W-1:0]  w_pc_inc;
   logic [ADDR_W-1:0]  w_redir_pc;
   logic [INSTR_W-1:0] w_rom_word;
   logic               w_unused;

   im_rom #(
      .IM_AW   (IM_AW),
      .INSTR_W (INSTR_W)
   ) u_im_rom (
      .i_addr (r_pc[IM_AW+1:2]),
      .o_word (w_rom_word)
   );

   assign w_pc_inc   = r_pc + ADDR_W'(PC_STEP);
   // Targets are word aligned by construction; the low byte-offset bits are dropped.
   assign w_redir_pc = {bus.Redir_Addr[ADDR_W-1:2], 2'b00};
   assign w_unused   = &{1'b0, bus.Redir_Addr[1:0]};

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_pc        <= RESET_VEC;
         r_if_pc     <= RESET_VEC;
         r_if_instr  <= INSTR_W'(NOP_WORD);
         r_if_valid  <= 1'b0;
         r_fetch_cnt <= '0;
      end else if (bus.Redir) begin
         r_pc        <= w_redir_pc;
         r_if_pc     <= r_pc;
         r_if_instr  <= INSTR_W'(NOP_WORD);
         r_if_valid  <= 1'b0;
      end else if (!bus.Stall) begin
         r_pc        <= w_pc_inc;
         r_if_pc     <= r_pc;
         r_if_instr  <= w_rom_word;
         r_if_valid  <= 1'b1;
         r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
   end

   assign bus.Pc        = r_pc;
   assign bus.If_Pc     = r_if_pc;
   assign bus.If_Instr  = r_if_instr;
   assign bus.If_Valid  = r_if_valid;
   assign bus.Fetch_Cnt = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: default build, high reset vector build, 4-bit counter build.
module tb_pc_fetch_unit;

   localparam logic [31:0] ROM0  = 32'hDEAD_0000;
   localparam logic [31:0] ROM1  = 32'hDEAC_0101;
   localparam logic [31:0] ROM2  = 32'hDEAF_0202;
   localparam logic [31:0] ROM3  = 32'hDEAE_0303;
   localparam logic [31:0] ROM4  = 32'hDEA9_0404;
   localparam logic [31:0] ROM8  = 32'hDEA5_0808;
   localparam logic [31:0] ROM16 = 32'hDEBD_1010;
   localparam logic [31:0] ROM62 = 32'hDE93_3E3E;
   localparam logic [31:0] ROM63 = 32'hDE92_3F3F;

   logic Clk;
   logic Rst;
   int   n_tests;
   int   n_fail;

   pc_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(16)) bus_m ();
   pc_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(16)) bus_h ();
   pc_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(4))  bus_c ();

   pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .IM_AW(6), .RESET_VEC(32'h0), .CNT_W(16))
      dut_m (.Clk(Clk), .Rst(Rst), .bus(bus_m));
   pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .IM_AW(6), .RESET_VEC(32'hFFFF_FFF8), .CNT_W(16))
      dut_h (.Clk(Clk), .Rst(Rst), .bus(bus_h));
   pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .IM_AW(6), .RESET_VEC(32'h0), .CNT_W(4))
      dut_c (.Clk(Clk), .Rst(Rst), .bus(bus_c));

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Called 1 time unit after a rising edge; reset is asserted and released between edges.
   task automatic pulse_reset();
      Rst = 1'b1;
      #2;
      Rst = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick(); tick();
      Rst = 1'b1;
      #2;
      n_tests++; if (bus_m.Pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp %h", bus_m.Pc, 32'h0); end
      n_tests++; if (bus_m.If_Pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc got %h exp %h", bus_m.If_Pc, 32'h0); end
      n_tests++; if (bus_m.If_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus_m.If_Valid); end
      n_tests++; if (bus_m.If_Instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp %h", bus_m.If_Instr, 32'h0); end
      n_tests++; if (bus_m.Fetch_Cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", bus_m.Fetch_Cnt); end
      n_tests++; if (bus_h.Pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rst_vec_pc got %h exp %h", bus_h.Pc, 32'hFFFF_FFF8); end
      Rst = 1'b0;
   endtask

   task automatic test_sequence();
      logic [31:0] exp_pc    [3];
      logic [31:0] exp_if_pc [3];
      logic [31:0] exp_instr [3];
      exp_pc    = '{32'h4, 32'h8, 32'hC};
      exp_if_pc = '{32'h0, 32'h4, 32'h8};
      exp_instr = '{ROM0, ROM1, ROM2};
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (bus_m.Pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, bus_m.Pc, exp_pc[i]); end
         n_tests++; if (bus_m.If_Pc !== exp_if_pc[i]) begin n_fail++; $display("FAIL seq_if_pc[%0d] got %h exp %h", i, bus_m.If_Pc, exp_if_pc[i]); end
         n_tests++; if (bus_m.If_Instr !== exp_instr[i]) begin n_fail++; $display("FAIL seq_instr[%0d] got %h exp %h", i, bus_m.If_Instr, exp_instr[i]); end
         n_tests++; if (bus_m.If_Valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b exp 1", i, bus_m.If_Valid); end
         n_tests++; if (bus_m.Fetch_Cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL seq_cnt[%0d] got %0d exp %0d", i, bus_m.Fetch_Cnt, i + 1); end
      end
   endtask

   task automatic test_stall();
      tick();
      n_tests++; if (bus_m.Pc !== 32'h10) begin n_fail++; $display("FAIL stall_pre_pc got %h exp %h", bus_m.Pc, 32'h10); end
      bus_m.Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (bus_m.Pc !== 32'h10) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp %h", i, bus_m.Pc, 32'h10); end
         n_tests++; if (bus_m.If_Pc !== 32'hC) begin n_fail++; $display("FAIL stall_if_pc[%0d] got %h exp %h", i, bus_m.If_Pc, 32'hC); end
         n_tests++; if (bus_m.If_Instr !== ROM3) begin n_fail++; $display("FAIL stall_instr[%0d] got %h exp %h", i, bus_m.If_Instr, ROM3); end
         n_tests++; if (bus_m.If_Valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 1", i, bus_m.If_Valid); end
         n_tests++; if (bus_m.Fetch_Cnt !== 16'd4) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d exp 4", i, bus_m.Fetch_Cnt); end
      end
      bus_m.Stall = 1'b0;
      tick();
      n_tests++; if (bus_m.Pc !== 32'h14) begin n_fail++; $display("FAIL resume_pc got %h exp %h", bus_m.Pc, 32'h14); end
      n_tests++; if (bus_m.If_Pc !== 32'h10) begin n_fail++; $display("FAIL resume_if_pc got %h exp %h", bus_m.If_Pc, 32'h10); end
      n_tests++; if (bus_m.If_Instr !== ROM4) begin n_fail++; $display("FAIL resume_instr got %h exp %h", bus_m.If_Instr, ROM4); end
      n_tests++; if (bus_m.Fetch_Cnt !== 16'd5) begin n_fail++; $display("FAIL resume_cnt got %0d exp 5", bus_m.Fetch_Cnt); end
   endtask

   task automatic test_redirect();
      pulse_reset();
      tick(); tick();
      n_tests++; if (bus_m.Pc !== 32'h8) begin n_fail++; $display("FAIL redir_pre_pc got %h exp %h", bus_m.Pc, 32'h8); end
      bus_m.Redir      = 1'b1;
      bus_m.Redir_Addr = 32'h40;
      tick();
      bus_m.Redir = 1'b0;
      n_tests++; if (bus_m.Pc !== 32'h40) begin n_fail++; $display("FAIL redir_pc got %h exp %h", bus_m.Pc, 32'h40); end
      n_tests++; if (bus_m.If_Valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got %b exp 0", bus_m.If_Valid); end
      n_tests++; if (bus_m.If_Instr !== 32'h0) begin n_fail++; $display("FAIL redir_nop got %h exp %h", bus_m.If_Instr, 32'h0); end
      n_tests++; if (bus_m.If_Pc !== 32'h8) begin n_fail++; $display("FAIL redir_if_pc got %h exp %h", bus_m.If_Pc, 32'h8); end
      n_tests++; if (bus_m.Fetch_Cnt !== 16'd2) begin n_fail++; $display("FAIL redir_cnt got %0d exp 2", bus_m.Fetch_Cnt); end
      tick();
      n_tests++; if (bus_m.If_Pc !== 32'h40) begin n_fail++; $display("FAIL tgt_if_pc got %h exp %h", bus_m.If_Pc, 32'h40); end
      n_tests++; if (bus_m.If_Instr !== ROM16) begin n_fail++; $display("FAIL tgt_instr got %h exp %h", bus_m.If_Instr, ROM16); end
      n_tests++; if (bus_m.If_Valid !== 1'b1) begin n_fail++; $display("FAIL tgt_valid got %b exp 1", bus_m.If_Valid); end
      n_tests++; if (bus_m.Pc !== 32'h44) begin n_fail++; $display("FAIL tgt_pc got %h exp %h", bus_m.Pc, 32'h44); end
      n_tests++; if (bus_m.Fetch_Cnt !== 16'd3) begin n_fail++; $display("FAIL tgt_cnt got %0d exp 3", bus_m.Fetch_Cnt); end
   endtask

   task automatic test_redir_over_stall();
      bus_m.Redir      = 1'b1;
      bus_m.Stall      = 1'b1;
      bus_m.Redir_Addr = 32'h23;
      tick();
      bus_m.Redir = 1'b0;
      bus_m.Stall = 1'b0;
      n_tests++; if (bus_m.Pc !== 32'h20) begin n_fail++; $display("FAIL rs_pc got %h exp %h", bus_m.Pc, 32'h20); end
      n_tests++; if (bus_m.If_Valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid got %b exp 0", bus_m.If_Valid); end
      n_tests++; if (bus_m.If_Instr !== 32'h0) begin n_fail++; $display("FAIL rs_nop got %h exp %h", bus_m.If_Instr, 32'h0); end
      n_tests++; if (bus_m.If_Pc !== 32'h44) begin n_fail++; $display("FAIL rs_if_pc got %h exp %h", bus_m.If_Pc, 32'h44); end
      n_tests++; if (bus_m.Fetch_Cnt !== 16'd3) begin n_fail++; $display("FAIL rs_cnt got %0d exp 3", bus_m.Fetch_Cnt); end
      tick();
      n_tests++; if (bus_m.If_Pc !== 32'h20) begin n_fail++; $display("FAIL rs_tgt_if_pc got %h exp %h", bus_m.If_Pc, 32'h20); end
      n_tests++; if (bus_m.If_Instr !== ROM8) begin n_fail++; $display("FAIL rs_tgt_instr got %h exp %h", bus_m.If_Instr, ROM8); end
      n_tests++; if (bus_m.Fetch_Cnt !== 16'd4) begin n_fail++; $display("FAIL rs_tgt_cnt got %0d exp 4", bus_m.Fetch_Cnt); end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] exp_pc    [3];
      logic [31:0] exp_instr [3];
      exp_pc    = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      exp_instr = '{ROM62, ROM63, ROM0};
      pulse_reset();
      n_tests++; if (bus_h.Pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_pc0 got %h exp %h", bus_h.Pc, 32'hFFFF_FFF8); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (bus_h.Pc !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, bus_h.Pc, exp_pc[i]); end
         n_tests++; if (bus_h.If_Instr !== exp_instr[i]) begin n_fail++; $display("FAIL wrap_instr[%0d] got %h exp %h", i, bus_h.If_Instr, exp_instr[i]); end
      end
   endtask

   task automatic test_cnt_wrap();
      pulse_reset();
      for (int i = 0; i < 16; i++) tick();
      n_tests++; if (bus_c.Fetch_Cnt !== 4'd0) begin n_fail++; $display("FAIL cnt16 got %0d exp 0", bus_c.Fetch_Cnt); end
      tick();
      n_tests++; if (bus_c.Fetch_Cnt !== 4'd1) begin n_fail++; $display("FAIL cnt17 got %0d exp 1", bus_c.Fetch_Cnt); end
      n_tests++; if (bus_c.Pc !== 32'h44) begin n_fail++; $display("FAIL cnt17_pc got %h exp %h", bus_c.Pc, 32'h44); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      Rst = 1'b1;
      bus_m.Stall = 1'b0; bus_m.Redir = 1'b0; bus_m.Redir_Addr = '0;
      bus_h.Stall = 1'b0; bus_h.Redir = 1'b0; bus_h.Redir_Addr = '0;
      bus_c.Stall = 1'b0; bus_c.Redir = 1'b0; bus_c.Redir_Addr = '0;
      #3;
      Rst = 1'b0;
      test_reset();
      test_sequence();
      test_stall();
      test_redirect();
      test_redir_over_stall();
      test_pc_wrap();
      test_cnt_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
